dice_button_conditioner: RTL
============================

Name: dice_button_conditioner

Overview:
- Upstream stage of digital_dice_top. Takes the raw, asynchronous, bouncy roll button and converts it into clean single-cycle events.
- Events produced: roll_pulse on each accepted press, release_pulse on each accepted release, and long_press once per hold.
- Also provides a debounced button level and a wrap-around count of accepted presses for status/debug.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples needed to accept a press or release; legal range 2..255.
- LONG_PRESS_CYCLES, 16: cycles spent in HELD before long_press fires; legal range 2..65535.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-low reset; 0 clears all state immediately.
- btn, input, 1: raw push-button, asynchronous to clk, may bounce.
- roll_pulse, output, 1: one-cycle pulse per accepted press; feeds the btn input of digital_dice_top.
- release_pulse, output, 1: one-cycle pulse per accepted release.
- long_press, output, 1: one-cycle pulse when a hold reaches LONG_PRESS_CYCLES.
- btn_level, output, 1: debounced level; 1 in HELD and DB_RELEASE.
- press_count, output, 8: accepted-press counter, wraps 255 -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync flops, FSM, debounce counter and hold counter clear.
  - State = IDLE; all outputs 0.
  - No events are generated while reset is held.
- Synchronizer: two flops, btn -> s1 -> btn_sync. The FSM sees only btn_sync.
- Debounce counter: dbc, 8 bits.
- Hold counter: hc, 16 bits, saturating.
- All outputs are registered.
- FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE.
- IDLE:
  - btn_sync=1 -> DB_PRESS, dbc=1.
  - Otherwise stay.
- DB_PRESS:
  - btn_sync=0 -> IDLE, no event (glitch rejected).
  - btn_sync=1 and dbc==DEBOUNCE_CYCLES-1 -> HELD; roll_pulse=1 for the next cycle; press_count+1; hc=0.
  - Otherwise dbc+1.
- HELD:
  - hc increments each cycle and saturates at LONG_PRESS_CYCLES.
  - On the cycle hc reaches LONG_PRESS_CYCLES-1, long_press=1 for one cycle. This fires at most once per accepted press.
  - btn_sync=0 -> DB_RELEASE, dbc=1.
- DB_RELEASE:
  - btn_sync=1 -> HELD. hc is not cleared, and there is no new roll_pulse or press_count change (release bounce is absorbed).
  - hc keeps counting in this state, so long_press may still fire here.
  - btn_sync=0 and dbc==DEBOUNCE_CYCLES-1 -> IDLE; release_pulse=1 for one cycle.
  - Otherwise dbc+1.
- Latency: btn first sampled high at edge E and held high gives roll_pulse high after edge E+1+DEBOUNCE_CYCLES, low after the next edge. Release latency is symmetric.
- Exclusivity:
  - roll_pulse and release_pulse are never high in the same cycle.
  - A roll_pulse is never followed by another roll_pulse without a release_pulse in between.
- Reset mid-operation:
  - Any pending event is dropped.
  - If btn is still high after reset deasserts, a full new debounce runs and exactly one roll_pulse is issued.
- press_count is reset only by reset and wraps silently.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, 100 ns clock):
- Clean press: btn=1 for 10 cycles, then 0. Required: exactly one roll_pulse, 5 cycles after the first sampling edge; btn_level=1 during the hold; one release_pulse after release; press_count=1.
- Glitch rejection: btn=1 for 1 cycle, and again for 2 cycles, separated by 5 low cycles. Required: no roll_pulse, no release_pulse, press_count=0.
- Bounce on press and release: btn toggles 1,0,1,0,1 then stays 1 for 20 cycles, then toggles 0,1,0 and stays 0. Required: exactly one roll_pulse and one long_press at hold cycle 16, exactly one release_pulse, press_count=1.
- Reset during hold: drive reset=0 for 1 cycle while in HELD with btn still 1. Required: outputs 0 immediately and press_count=0; after reset=1, one new roll_pulse 5 cycles later and press_count=1.
- Counter wrap: 257 clean presses. Required: press_count=1 and 257 roll_pulses.
- Short press: hold 8 cycles. Required: no long_press; roll_pulse and release_pulse each exactly once.

Source files
------------

// File: rtl/dice_button_conditioner.sv
// rtl/dice_button_conditioner.sv - synchronizes and debounces the roll button into clean press/release/long-press events
module dice_button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int LONG_PRESS_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    output logic       roll_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic       btn_level,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HC_MAX  = 16'(LONG_PRESS_CYCLES);
    localparam logic [15:0] HC_FIRE = 16'(LONG_PRESS_CYCLES - 1);

    state_t      state_q;
    logic        s1_q;
    logic        sync_q;
    logic [7:0]  dbc_q;
    logic [15:0] hc_q;
    logic        roll_q;
    logic        release_q;
    logic        long_q;
    logic        level_q;
    logic [7:0]  count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            sync_q    <= 1'b0;
            dbc_q     <= 8'd0;
            hc_q      <= 16'd0;
            roll_q    <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            level_q   <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            s1_q      <= btn;
            sync_q    <= s1_q;
            roll_q    <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            // Hold time keeps accruing through release bounce; saturation stops a second long_press.
            if (state_q == HELD || state_q == DB_RELEASE) begin
                if (hc_q != HC_MAX) begin
                    hc_q <= hc_q + 16'd1;
                end
                if (hc_q == HC_FIRE) begin
                    long_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (sync_q) begin
                        state_q <= DB_PRESS;
                        dbc_q   <= 8'd1;
                    end
                end
                DB_PRESS: begin
                    if (!sync_q) begin
                        state_q <= IDLE;
                    end else if (dbc_q == DB_LAST) begin
                        state_q <= HELD;
                        roll_q  <= 1'b1;
                        level_q <= 1'b1;
                        count_q <= count_q + 8'd1;
                        hc_q    <= 16'd0;
                    end else begin
                        dbc_q <= dbc_q + 8'd1;
                    end
                end
                HELD: begin
                    if (!sync_q) begin
                        state_q <= DB_RELEASE;
                        dbc_q   <= 8'd1;
                    end
                end
                DB_RELEASE: begin
                    if (sync_q) begin
                        state_q <= HELD;
                    end else if (dbc_q == DB_LAST) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                    end else begin
                        dbc_q <= dbc_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign roll_pulse    = roll_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign btn_level     = level_q;
    assign press_count   = count_q;

endmodule
